// File: rtl/btn_debounce_toggle.sv
// btn_debounce_toggle
//   Multi-channel pushbutton front end on the 12 MHz system clock. Each channel
//   runs: 2-FF synchroniser -> polarity normalisation -> counter debounce ->
//   press/release/long-press strobes -> LED driver (toggle or follow).
//   Channels share no state.
//
// Ports
//   CLK            system clock, all logic on rising edge
//   RST            synchronous active-high reset
//   btn[N_CH]      raw asynchronous button pins
//   pressed        debounced pressed state (1 = pressed)
//   press_pulse    1-cycle strobe when a press is accepted
//   release_pulse  1-cycle strobe when a release is accepted
//   long_pulse     1-cycle strobe once a press has been held LONG_CYCLES
//   led            LED drive (1 = on)
//
// Parameters
//   DEBOUNCE_CYCLES  cycles a new level must persist before it is accepted
//   LONG_CYCLES      cycles a debounced press is held before long_pulse
//   ACTIVE_LOW       1: pin low = pressed
//   MODE             0: led toggles on press, cleared by long press
//                    1: led follows pressed
module btn_debounce_toggle #(
  parameter int N_CH            = 2,
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int LONG_CYCLES     = 12000000,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter bit MODE            = 1'b0
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [N_CH-1:0] btn,
  output logic [N_CH-1:0] pressed,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] long_pulse,
  output logic [N_CH-1:0] led
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [N_CH-1:0]   IDLE_LVL  = {N_CH{ACTIVE_LOW}};

  logic [N_CH-1:0] sync1_q, sync1_d;
  logic [N_CH-1:0] sync2_q, sync2_d;
  logic [N_CH-1:0] pressed_q, pressed_d;
  logic [N_CH-1:0] press_pulse_q, press_pulse_d;
  logic [N_CH-1:0] release_pulse_q, release_pulse_d;
  logic [N_CH-1:0] long_pulse_q, long_pulse_d;
  logic [N_CH-1:0] led_q, led_d;
  logic [N_CH-1:0] fired_q, fired_d;

  logic [N_CH-1:0][DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [N_CH-1:0][HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  // Normalised synchronised sample: 1 = pressed regardless of pin polarity.
  logic [N_CH-1:0] samp;
  assign samp = sync2_q ^ IDLE_LVL;

  always_comb begin
    sync1_d         = btn;
    sync2_d         = sync1_q;
    pressed_d       = pressed_q;
    press_pulse_d   = '0;
    release_pulse_d = '0;
    long_pulse_d    = '0;
    led_d           = led_q;
    fired_d         = fired_q;
    db_cnt_d        = db_cnt_q;
    hold_cnt_d      = hold_cnt_q;

    for (int i = 0; i < N_CH; i++) begin
      // Debounce: count consecutive samples that disagree with the accepted
      // level; any agreeing sample restarts the count.
      if (samp[i] == pressed_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        db_cnt_d[i]        = '0;
        pressed_d[i]       = samp[i];
        press_pulse_d[i]   = samp[i];
        release_pulse_d[i] = ~samp[i];
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end

      // Long press: counts from the registered pressed level, so long_pulse
      // lands exactly LONG_CYCLES after press_pulse. The counter holds once
      // fired, giving one event per press.
      if (!pressed_q[i]) begin
        hold_cnt_d[i] = '0;
        fired_d[i]    = 1'b0;
      end else if (!fired_q[i]) begin
        if (hold_cnt_q[i] == HOLD_LAST) begin
          long_pulse_d[i] = 1'b1;
          fired_d[i]      = 1'b1;
        end else begin
          hold_cnt_d[i] = hold_cnt_q[i] + 1'b1;
        end
      end

      if (!MODE) begin
        if (press_pulse_d[i]) led_d[i] = ~led_q[i];
        if (long_pulse_d[i])  led_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q         <= IDLE_LVL;
      sync2_q         <= IDLE_LVL;
      pressed_q       <= '0;
      press_pulse_q   <= '0;
      release_pulse_q <= '0;
      long_pulse_q    <= '0;
      led_q           <= '0;
      fired_q         <= '0;
      db_cnt_q        <= '0;
      hold_cnt_q      <= '0;
    end else begin
      sync1_q         <= sync1_d;
      sync2_q         <= sync2_d;
      pressed_q       <= pressed_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      long_pulse_q    <= long_pulse_d;
      led_q           <= led_d;
      fired_q         <= fired_d;
      db_cnt_q        <= db_cnt_d;
      hold_cnt_q      <= hold_cnt_d;
    end
  end

  assign pressed       = pressed_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
  assign long_pulse    = long_pulse_q;
  // Follow mode drives the LED straight from the registered pressed state.
  assign led           = MODE ? pressed_q : led_q;

endmodule

// File: tb/tb_btn_debounce_toggle.sv
// Testbench for btn_debounce_toggle. Two instances share the stimulus: dut0 in
// toggle mode and dut1 in follow mode. A behavioural model keeps the history of
// synchronised samples per channel and flips the pressed state when the last
// DEBOUNCE_CYCLES samples all disagree with it; long presses are timed from the
// edge of the accepted press.
module tb_btn_debounce_toggle;

  localparam int N_CH = 2;
  localparam int D    = 4;
  localparam int L    = 10;
  localparam bit AL   = 1'b1;
  localparam int MAXE = 20000;

  logic            CLK;
  logic            RST;
  logic [N_CH-1:0] btn;

  logic [N_CH-1:0] d0_pressed, d0_pp, d0_rp, d0_lp, d0_led;
  logic [N_CH-1:0] d1_pressed, d1_pp, d1_rp, d1_lp, d1_led;

  int tests = 0;
  int fails = 0;

  btn_debounce_toggle #(.N_CH(N_CH), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L),
                        .ACTIVE_LOW(AL), .MODE(1'b0)) dut0 (
    .CLK(CLK), .RST(RST), .btn(btn),
    .pressed(d0_pressed), .press_pulse(d0_pp), .release_pulse(d0_rp),
    .long_pulse(d0_lp), .led(d0_led));

  btn_debounce_toggle #(.N_CH(N_CH), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L),
                        .ACTIVE_LOW(AL), .MODE(1'b1)) dut1 (
    .CLK(CLK), .RST(RST), .btn(btn),
    .pressed(d1_pressed), .press_pulse(d1_pp), .release_pulse(d1_rp),
    .long_pulse(d1_lp), .led(d1_led));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // ---------------- behavioural model ----------------
  bit              hist [N_CH][MAXE];
  int              e = D + 2;
  int              press_edge [N_CH];
  logic [N_CH-1:0] m_pressed = '0, m_pp = '0, m_rp = '0, m_lp = '0, m_led = '0;
  bit              m_valid = 1'b0;

  always @(posedge CLK) begin
    bit pre, differ;
    if (e < MAXE - 1) e = e + 1;
    if (RST) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        hist[ch][e]     = 1'b0;
        hist[ch][e - 1] = 1'b0;
        press_edge[ch]  = -1000;
      end
      m_pressed = '0; m_pp = '0; m_rp = '0; m_lp = '0; m_led = '0;
      m_valid   = 1'b1;
    end else begin
      for (int ch = 0; ch < N_CH; ch++) begin
        hist[ch][e] = btn[ch] ^ AL;
        pre    = m_pressed[ch];
        differ = 1'b1;
        for (int k = 0; k < D; k++)
          if (hist[ch][e - 2 - k] == pre) differ = 1'b0;
        m_lp[ch] = pre && ((e - press_edge[ch]) == L);
        m_pp[ch] = differ && !pre;
        m_rp[ch] = differ && pre;
        if (differ) m_pressed[ch] = ~pre;
        if (m_pp[ch]) begin
          press_edge[ch] = e;
          m_led[ch]      = ~m_led[ch];
        end
        if (m_lp[ch]) m_led[ch] = 1'b0;
      end
    end
  end

  always @(negedge CLK) begin
    if (m_valid) begin
      chk("d0_pressed", 32'(d0_pressed), 32'(m_pressed));
      chk("d0_press_pulse", 32'(d0_pp), 32'(m_pp));
      chk("d0_release_pulse", 32'(d0_rp), 32'(m_rp));
      chk("d0_long_pulse", 32'(d0_lp), 32'(m_lp));
      chk("d0_led", 32'(d0_led), 32'(m_led));
      chk("d1_pressed", 32'(d1_pressed), 32'(m_pressed));
      chk("d1_press_pulse", 32'(d1_pp), 32'(m_pp));
      chk("d1_release_pulse", 32'(d1_rp), 32'(m_rp));
      chk("d1_long_pulse", 32'(d1_lp), 32'(m_lp));
      chk("d1_led_follow", 32'(d1_led), 32'(m_pressed));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  // ---------------- stimulus and literal expectations ----------------
  initial begin
    int cnt, cnt2, ledge, pedge, max_p;
    bit lvl [N_CH];
    int rem [N_CH];

    RST = 1'b1;
    btn = '1;
    repeat (3) step();
    chk("reset_outputs", 32'({d0_pressed, d0_pp, d0_rp, d0_lp, d0_led}), 32'd0);
    RST = 1'b0;
    repeat (4) step();

    // 1: clean press on channel 0
    btn[0] = 1'b0;
    repeat (5) step();
    chk("s1_pressed_edge5", 32'(d0_pressed[0]), 32'd0);
    step();
    chk("s1_pressed_edge6", 32'(d0_pressed[0]), 32'd1);
    chk("s1_press_pulse_edge6", 32'(d0_pp[0]), 32'd1);
    chk("s1_led_edge6", 32'(d0_led[0]), 32'd1);
    step();
    chk("s1_press_pulse_edge7", 32'(d0_pp[0]), 32'd0);
    chk("s1_led_edge7", 32'(d0_led[0]), 32'd1);
    chk("s1_ch1_idle", 32'({d0_pressed[1], d0_led[1]}), 32'd0);

    // 3: release then second press
    btn[0] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      cnt += int'(d0_rp[0]);
    end
    chk("s3_release_count", 32'(cnt), 32'd1);
    chk("s3_led_after_release", 32'(d0_led[0]), 32'd1);
    btn[0] = 1'b0;
    repeat (6) step();
    chk("s3_second_press_pulse", 32'(d0_pp[0]), 32'd1);
    chk("s3_led_toggled_off", 32'(d0_led[0]), 32'd0);
    btn[0] = 1'b1;
    repeat (8) step();

    // 2: bounce rejection
    max_p = 0; cnt = 0;
    for (int i = 0; i < 15; i++) begin
      btn[0] = (i == 3 || i >= 7) ? 1'b1 : 1'b0;
      step();
      if (d0_pressed[0]) max_p = 1;
      cnt += int'(d0_pp[0]);
    end
    chk("s2_never_pressed", 32'(max_p), 32'd0);
    chk("s2_no_press_pulse", 32'(cnt), 32'd0);
    chk("s2_led_off", 32'(d0_led[0]), 32'd0);

    // 4: long press on channel 1
    btn[1] = 1'b0;
    cnt = 0; cnt2 = 0; ledge = 0; pedge = 0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (d0_pp[1]) begin cnt2++; pedge = i; end
      if (i == 6) chk("s4_led_on_press", 32'(d0_led[1]), 32'd1);
      if (d0_lp[1]) begin
        cnt++; ledge = i;
        chk("s4_led_cleared_by_long", 32'(d0_led[1]), 32'd0);
      end
    end
    chk("s4_press_edge", 32'(pedge), 32'd6);
    chk("s4_press_count", 32'(cnt2), 32'd1);
    chk("s4_long_count", 32'(cnt), 32'd1);
    chk("s4_long_edge", 32'(ledge), 32'd16);
    btn[1] = 1'b1;
    repeat (8) step();

    // 5: reset in the middle of a debounce count
    btn[0] = 1'b0;
    step(); step();
    RST = 1'b1;
    step();
    chk("s5_reset_outputs", 32'({d0_pressed, d0_pp, d0_rp, d0_lp, d0_led}), 32'd0);
    RST = 1'b0;
    repeat (5) step();
    chk("s5_not_yet_pressed", 32'(d0_pressed[0]), 32'd0);
    step();
    chk("s5_pressed_after_reset", 32'(d0_pressed[0]), 32'd1);
    btn[0] = 1'b1;
    repeat (8) step();

    // 6: both channels together, follow mode
    btn = '0;
    repeat (6) step();
    chk("s6_both_press_pulse", 32'(d1_pp), 32'd3);
    chk("s6_led_follows", 32'(d1_led), 32'd3);
    btn = '1;
    repeat (6) step();
    chk("s6_led_follows_release", 32'(d1_led), 32'd0);
    repeat (4) step();

    // randomised bursts with occasional resets
    for (int ch = 0; ch < N_CH; ch++) begin lvl[ch] = 1'b1; rem[ch] = 0; end
    for (int c = 0; c < 3000; c++) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        if (rem[ch] == 0) begin
          lvl[ch] = ~lvl[ch];
          rem[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 25))
                                                : int'($urandom_range(1, 6));
        end
        btn[ch] = lvl[ch];
        rem[ch]--;
      end
      RST = ($urandom_range(0, 249) == 0);
      step();
    end
    RST = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
